keypad_cmd_parser: RTL
======================

Name: keypad_cmd_parser

Overview:
- Parametrised successor of the fixed keypad-sequence FSM.
- Parses a strobed key stream into a frame: START key, N_DIGITS decimal digits, N_FLAGS binary flags, then END key. Each field is confirmed with ENTER.
- Fields build up in shadow registers and are copied to registered outputs only when the full frame completes; cmd_done then enables the downstream control FSM.
- Adds CANCEL, inactivity timeout, an optional strict mode, and error reporting.

Parameters:
- N_DIGITS, 2: number of decimal digit fields, 1..8.
- N_FLAGS, 2: number of binary flag fields, 1..8.
- TIMEOUT_CYCLES, 1000000: idle cycles allowed mid-frame before abort; 0 disables the timeout.
- STRICT, 0: 1 means an unexpected key aborts the frame with an error; 0 means it is ignored.
- K_START, 4'hA; K_ENTER, 4'hC; K_END, 4'hB; K_CANCEL, 4'hE: key codes.

Ports:
- CLK  in  1  clock
- Reset  in  1  synchronous, active-high reset
- key_valid  in  1  one-cycle strobe; key fields are sampled only when it is 1
- tvalida  in  4  key code
- esnumero  in  1  key is numeric (0..9)
- digits  out  4*N_DIGITS  committed BCD digits; digit 0 (first entered) in [3:0]
- flags  out  N_FLAGS  committed flags; flag 0 (first entered) in bit 0
- cmd_done  out  1  one-cycle pulse after commit (enable for FSM1)
- err  out  1  one-cycle pulse on abort
- err_code  out  2  0 none, 1 cancel, 2 timeout, 3 bad key; held until the next err or START
- busy  out  1  1 in every state except WAIT_START
- field_idx  out  4  index of the field being entered (0..N_DIGITS+N_FLAGS-1)

Behaviour:
- Reset (any state, any cycle): state=WAIT_START; digits=0, flags=0, cmd_done=0, err=0, err_code=0, field_idx=0; shadow registers and timeout counter cleared. Reset has priority over every other event.
- All outputs are registered and change on the CLK edge after the accepted key.
- A key is accepted only on a cycle with key_valid=1; nothing advances on other cycles.
- WAIT_START: K_START → DIGIT, field_idx=0, err_code=0.
- DIGIT: a key with esnumero=1 and tvalida<=9 loads shadow digit[field_idx] → DIGIT_CONF.
- DIGIT_CONF: K_ENTER → next DIGIT (field_idx+1), or FLAG after the last digit.
- FLAG: tvalida 0 or 1 loads shadow flag → FLAG_CONF.
- FLAG_CONF: K_ENTER → next FLAG, or END_KEY after the last flag.
- END_KEY: K_END → END_CONF.
- END_CONF: K_ENTER commits shadows to digits/flags; the next cycle cmd_done=1 for exactly one cycle; state → WAIT_START.
- A digit or flag key may be re-entered while in its _CONF state: the new value overwrites the shadow and the state stays.
- Unexpected key:
  - STRICT=0: ignored, no state change. The timeout counter is still reset.
  - STRICT=1: abort with code 3.
- K_CANCEL while busy aborts with code 1. K_CANCEL in WAIT_START is ignored.
- Timeout:
  - The counter resets to 0 on every accepted key and runs only while busy.
  - Reaching TIMEOUT_CYCLES-1 aborts with code 2.
- Abort: state → WAIT_START, err pulses for 1 cycle, err_code is set, shadows are cleared. Committed digits/flags keep their previous values and cmd_done does not pulse.
- Priority within one cycle: Reset > CANCEL > timeout > normal key handling.
- K_START while busy:
  - STRICT=0: restarts the frame (shadows cleared, field_idx=0, no err).
  - STRICT=1: abort with code 3.
- Counter width is $clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.

Test Plan:
- Default parameters. Keys A,7,C,3,C,1,C,0,C,B,C → digits=8'h37, flags=2'b01; cmd_done pulses 1 cycle after the last C; busy=0.
- Send A,7,C,E. Before that frame, digits=8'h37 → err=1 for 1 cycle, err_code=1, digits still 8'h37, no cmd_done.
- TIMEOUT_CYCLES=16. Send A,5, then idle → err pulses exactly 16 cycles after the '5', err_code=2, state WAIT_START.
- STRICT=0: send A,C (ENTER without a digit) → ignored, field_idx=0, still waiting for a digit. Same with STRICT=1 → err_code=3.
- Flag field receives 5 with STRICT=0 → ignored. Send 1 then 0 before C → committed flag is 0.
- Assert Reset in FLAG_CONF → all outputs 0 on the next edge. Then send a full frame → it commits normally. Also hold key_valid=0 with tvalida=A → no state change.

Source files
------------

// File: rtl/keypad_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : keypad_cmd_parser
// Description : Parses a strobed key stream into a command frame:
//               START, N_DIGITS BCD digits, N_FLAGS binary flags, END, with
//               each field confirmed by ENTER. Fields accumulate in shadow
//               registers and are committed to the outputs only when the
//               frame completes. Supports CANCEL, inactivity timeout, strict
//               mode and error reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_cmd_parser #(
  parameter int         N_DIGITS       = 2,
  parameter int         N_FLAGS        = 2,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         STRICT         = 0,
  parameter logic [3:0] K_START        = 4'hA,
  parameter logic [3:0] K_ENTER        = 4'hC,
  parameter logic [3:0] K_END          = 4'hB,
  parameter logic [3:0] K_CANCEL       = 4'hE
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  key_valid,
  input  logic [3:0]            tvalida,
  input  logic                  esnumero,
  output logic [4*N_DIGITS-1:0] digits,
  output logic [N_FLAGS-1:0]    flags,
  output logic                  cmd_done,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic                  busy,
  output logic [3:0]            field_idx
);

  // Timeout counter sized so TIMEOUT_CYCLES itself is representable;
  // a disabled timeout still gets a 1-bit counter to keep widths legal.
  localparam int c_cnt_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_tmo_last =
    (TIMEOUT_CYCLES > 0) ? c_cnt_w'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [3:0] c_last_digit = 4'(N_DIGITS - 1);
  localparam logic [3:0] c_last_flag  = 4'(N_DIGITS + N_FLAGS - 1);

  localparam logic [1:0] c_err_cancel  = 2'd1;
  localparam logic [1:0] c_err_timeout = 2'd2;
  localparam logic [1:0] c_err_badkey  = 2'd3;

  typedef enum logic [2:0] {
    S_WAIT_START = 3'd0,
    S_DIGIT      = 3'd1,
    S_DIGIT_CONF = 3'd2,
    S_FLAG       = 3'd3,
    S_FLAG_CONF  = 3'd4,
    S_END_KEY    = 3'd5,
    S_END_CONF   = 3'd6
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic [4*N_DIGITS-1:0]   r_sh_dig;
  logic [N_FLAGS-1:0]      r_sh_flg;
  logic [4*N_DIGITS-1:0]   r_digits;
  logic [N_FLAGS-1:0]      r_flags;
  logic                    r_cmd_done;
  logic                    r_err;
  logic [1:0]              r_err_code;
  logic                    r_busy;
  logic [3:0]              r_idx;
  logic [c_cnt_w-1:0]      r_cnt;

  logic                    w_is_digit;
  logic                    w_is_flag;
  logic                    w_tmo;
  logic                    w_ld_dig;
  logic                    w_ld_flag;
  logic                    w_commit;
  logic                    w_abort;
  logic [1:0]              w_code;
  logic                    w_clr_sh;
  logic                    w_start;
  logic                    w_unexp;
  logic [3:0]              w_idx_nxt;

  assign w_is_digit = esnumero && (tvalida <= 4'd9);
  assign w_is_flag  = (tvalida <= 4'd1);
  assign w_tmo      = (TIMEOUT_CYCLES != 0) && (r_state != S_WAIT_START) &&
                      (r_cnt == c_tmo_last);

  // State register
  always_ff @(posedge CLK) begin
    if (Reset) r_state <= S_WAIT_START;
    else       r_state <= w_state_nxt;
  end

  // Next-state and control decode; CANCEL beats timeout beats normal keys
  always_comb begin
    w_state_nxt = r_state;
    w_ld_dig    = 1'b0;
    w_ld_flag   = 1'b0;
    w_commit    = 1'b0;
    w_abort     = 1'b0;
    w_code      = 2'd0;
    w_clr_sh    = 1'b0;
    w_start     = 1'b0;
    w_unexp     = 1'b0;
    w_idx_nxt   = r_idx;

    if (key_valid && (r_state != S_WAIT_START) && (tvalida == K_CANCEL)) begin
      w_abort = 1'b1;
      w_code  = c_err_cancel;
    end else if (w_tmo) begin
      w_abort = 1'b1;
      w_code  = c_err_timeout;
    end else if (key_valid) begin
      if (r_state == S_WAIT_START) begin
        // Anything other than START is meaningless outside a frame
        if (tvalida == K_START) begin
          w_state_nxt = S_DIGIT;
          w_idx_nxt   = 4'd0;
          w_start     = 1'b1;
          w_clr_sh    = 1'b1;
        end
      end else if (tvalida == K_START) begin
        if (STRICT != 0) begin
          w_unexp = 1'b1;
        end else begin
          w_state_nxt = S_DIGIT;
          w_idx_nxt   = 4'd0;
          w_start     = 1'b1;
          w_clr_sh    = 1'b1;
        end
      end else begin
        case (r_state)
          S_DIGIT: begin
            if (w_is_digit) begin
              w_ld_dig    = 1'b1;
              w_state_nxt = S_DIGIT_CONF;
            end else begin
              w_unexp = 1'b1;
            end
          end
          S_DIGIT_CONF: begin
            if (tvalida == K_ENTER) begin
              w_state_nxt = (r_idx == c_last_digit) ? S_FLAG : S_DIGIT;
              w_idx_nxt   = r_idx + 4'd1;
            end else if (w_is_digit) begin
              w_ld_dig = 1'b1;
            end else begin
              w_unexp = 1'b1;
            end
          end
          S_FLAG: begin
            if (w_is_flag) begin
              w_ld_flag   = 1'b1;
              w_state_nxt = S_FLAG_CONF;
            end else begin
              w_unexp = 1'b1;
            end
          end
          S_FLAG_CONF: begin
            if (tvalida == K_ENTER) begin
              if (r_idx == c_last_flag) begin
                w_state_nxt = S_END_KEY;
              end else begin
                w_state_nxt = S_FLAG;
                w_idx_nxt   = r_idx + 4'd1;
              end
            end else if (w_is_flag) begin
              w_ld_flag = 1'b1;
            end else begin
              w_unexp = 1'b1;
            end
          end
          S_END_KEY: begin
            if (tvalida == K_END) w_state_nxt = S_END_CONF;
            else                  w_unexp     = 1'b1;
          end
          S_END_CONF: begin
            if (tvalida == K_ENTER) begin
              w_commit    = 1'b1;
              w_state_nxt = S_WAIT_START;
              w_clr_sh    = 1'b1;
            end else begin
              w_unexp = 1'b1;
            end
          end
          default: w_state_nxt = S_WAIT_START;
        endcase
      end

      if (w_unexp && (STRICT != 0)) begin
        w_abort  = 1'b1;
        w_code   = c_err_badkey;
        w_ld_dig = 1'b0;
        w_ld_flag = 1'b0;
      end
    end

    if (w_abort) begin
      w_state_nxt = S_WAIT_START;
      w_clr_sh    = 1'b1;
      w_commit    = 1'b0;
    end
    if (w_state_nxt == S_WAIT_START) w_idx_nxt = 4'd0;
  end

  // Registered outputs and shadow field storage
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_sh_dig   <= '0;
      r_sh_flg   <= '0;
      r_digits   <= '0;
      r_flags    <= '0;
      r_cmd_done <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
      r_busy     <= 1'b0;
      r_idx      <= 4'd0;
    end else begin
      r_cmd_done <= w_commit;
      r_err      <= w_abort;
      r_busy     <= (w_state_nxt != S_WAIT_START);
      r_idx      <= w_idx_nxt;
      if (w_abort)      r_err_code <= w_code;
      else if (w_start) r_err_code <= 2'd0;
      if (w_commit) begin
        r_digits <= r_sh_dig;
        r_flags  <= r_sh_flg;
      end
      if (w_clr_sh) begin
        r_sh_dig <= '0;
        r_sh_flg <= '0;
      end else begin
        for (int i = 0; i < N_DIGITS; i++) begin
          if (w_ld_dig && (r_idx == 4'(i))) r_sh_dig[4*i +: 4] <= tvalida;
        end
        for (int i = 0; i < N_FLAGS; i++) begin
          if (w_ld_flag && (r_idx == 4'(N_DIGITS + i))) r_sh_flg[i] <= tvalida[0];
        end
      end
    end
  end

  // Inactivity counter: cleared by any key or when idle, saturates otherwise
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_cnt <= '0;
    end else if (key_valid || (w_state_nxt == S_WAIT_START)) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign digits    = r_digits;
  assign flags     = r_flags;
  assign cmd_done  = r_cmd_done;
  assign err       = r_err;
  assign err_code  = r_err_code;
  assign busy      = r_busy;
  assign field_idx = r_idx;

endmodule
`default_nettype wire
